q_sweep_sequencer: RTL and testbench

Synthesizable setpoint-sweep sequencer for the Q control loop. It drives q_desired through N_POINTS windowed setpoints and holds the control-loop enable. For each point it waits for converged or a timeout, then pulses a loop reset between points and records per-point results and pass/timeout tallies. It replaces bench-only sweep code, so a sweep can run on silicon or FPGA against the real or emulated resonant system.

---
 rtl/q_sweep_if.sv | 52 +++++
 rtl/q_sweep_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_q_sweep_sequencer.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/q_sweep_if.sv
// Sweep sequencer bus: control inputs, setpoint/loop controls and results.
// SWEEP_STOP_ON_TIMEOUT_EN adds sweep_err.
interface q_sweep_if #(
  parameter int BUS_WIDTH      = 10,
  parameter int N_POINTS       = 4,
  parameter int TIMEOUT_CYCLES = 5000
);
  localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(N_POINTS + 1);

  logic                 start;
  logic                 abort;
  logic                 mode;
  logic                 converged;
  logic [BUS_WIDTH-1:0] q_desired;
  logic                 loop_en;
  logic                 loop_rst;
  logic                 busy;
  logic                 done;
  logic                 res_valid;
  logic [IW-1:0]        res_idx;
  logic                 res_timeout;
  logic [CW-1:0]        res_cycles;
  logic [NW-1:0]        pass_cnt;
  logic [NW-1:0]        tmo_cnt;
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
  logic                 sweep_err;
`endif

  modport master (
    input  start, abort, mode, converged,
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
    output sweep_err,
`endif
    output q_desired, loop_en, loop_rst,
    output busy, done, res_valid, res_idx,
    output res_timeout, res_cycles,
    output pass_cnt, tmo_cnt
  );

  modport slave (
    output start, abort, mode, converged,
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
    input  sweep_err,
`endif
    input  q_desired, loop_en, loop_rst,
    input  busy, done, res_valid, res_idx,
    input  res_timeout, res_cycles,
    input  pass_cnt, tmo_cnt
  );
endinterface

// File: rtl/q_sweep_sequencer.sv
// Setpoint sweep sequencer for the Q control loop.
// Optional: SWEEP_STOP_ON_TIMEOUT_EN ends the sweep on the first timeout.
module q_sweep_sequencer #(
  parameter int          BUS_WIDTH      = 10,
  parameter int          N_POINTS       = 4,
  parameter int          STEP           = 20,
  parameter int          TIMEOUT_CYCLES = 5000,
  parameter int          RST_CYCLES     = 5,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  q_sweep_if.master  bus
);
  localparam int IW = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int NW = $clog2(N_POINTS + 1);
  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;
  localparam int BW = BUS_WIDTH;
  localparam logic [31:0] MAXV = (32'd1 << BW) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_LOAD, S_RUN,
    S_REC, S_GAP, S_DONE
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          mode_q, mode_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [BW-1:0] q_q, q_d;
  logic [NW-1:0] pass_q, pass_d;
  logic [NW-1:0] tmo_q, tmo_d;
  logic [IW-1:0] ridx_q, ridx_d;
  logic          rtmo_q, rtmo_d;
  logic [CW-1:0] rcyc_q, rcyc_d;
  logic          err_q, err_d;

  logic          rst_last, idx_last, tmo_hit;
  logic [15:0]   lfsr_nx;
  logic [31:0]   lo_w, span_w, off_w, sum_w;
  logic [BW-1:0] sp;

  assign rst_last = (rcnt_q == RW'(RST_CYCLES - 1));
  assign idx_last = (idx_q == IW'(N_POINTS - 1));
  assign tmo_hit  = (cyc_q == CW'(TIMEOUT_CYCLES));
  assign lfsr_nx  = lfsr_q[0] ? ({1'b0, lfsr_q[15:1]} ^ 16'hB400)
                              : {1'b0, lfsr_q[15:1]};

  // Window lo_i = STEP*(i+2), random offset scaled into [0, STEP*(i+1)]
  always_comb begin
    lo_w   = 32'(STEP) * (32'(idx_q) + 32'd2);
    span_w = 32'(STEP) * (32'(idx_q) + 32'd1);
    off_w  = (32'(lfsr_q) * (span_w + 32'd1)) >> 16;
    sum_w  = lo_w + (mode_q ? off_w : 32'd0);
    sp     = (sum_w > MAXV) ? MAXV[BW-1:0] : sum_w[BW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE:
          if (bus.start) state_d = S_PRE;
        S_PRE:
          if (rst_last) state_d = S_LOAD;
        S_LOAD:
          state_d = S_RUN;
        S_RUN:
          if (bus.converged || tmo_hit) state_d = S_REC;
        S_REC:
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
          state_d = rtmo_q ? S_DONE : S_GAP;
`else
          state_d = S_GAP;
`endif
        S_GAP:
          if (rst_last) state_d = idx_last ? S_DONE : S_LOAD;
        default:
          state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    idx_d  = idx_q;
    mode_d = mode_q;
    lfsr_d = lfsr_q;
    q_d    = q_q;
    pass_d = pass_q;
    tmo_d  = tmo_q;
    ridx_d = ridx_q;
    rtmo_d = rtmo_q;
    rcyc_d = rcyc_q;
    err_d  = err_q;
    rcnt_d = '0;
    if ((state_q == S_PRE || state_q == S_GAP) && state_d == state_q)
      rcnt_d = rcnt_q + 1'b1;
    cyc_d = (state_q == S_RUN) ? cyc_q + 1'b1 : CW'(1);
    if ((state_q == S_IDLE || state_q == S_DONE) && state_d == S_PRE) begin
      idx_d  = '0;
      pass_d = '0;
      tmo_d  = '0;
      mode_d = bus.mode;
      err_d  = 1'b0;
    end
    if (state_q == S_LOAD && state_d == S_RUN) begin
      q_d    = sp;
      lfsr_d = lfsr_nx;
    end
    if (state_q == S_RUN && state_d == S_REC) begin
      ridx_d = idx_q;
      rtmo_d = !bus.converged;
      rcyc_d = cyc_q;
      if (bus.converged) pass_d = pass_q + 1'b1;
      else               tmo_d  = tmo_q + 1'b1;
    end
    if (state_q == S_GAP && state_d == S_LOAD)
      idx_d = idx_q + 1'b1;
    if (state_q == S_REC && state_d == S_DONE)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rcnt_q <= '0;
      cyc_q  <= '0;
      idx_q  <= '0;
      mode_q <= 1'b0;
      lfsr_q <= LFSR_SEED;
      q_q    <= '0;
      pass_q <= '0;
      tmo_q  <= '0;
      ridx_q <= '0;
      rtmo_q <= 1'b0;
      rcyc_q <= '0;
      err_q  <= 1'b0;
    end else begin
      rcnt_q <= rcnt_d;
      cyc_q  <= cyc_d;
      idx_q  <= idx_d;
      mode_q <= mode_d;
      lfsr_q <= lfsr_d;
      q_q    <= q_d;
      pass_q <= pass_d;
      tmo_q  <= tmo_d;
      ridx_q <= ridx_d;
      rtmo_q <= rtmo_d;
      rcyc_q <= rcyc_d;
      err_q  <= err_d;
    end
  end

  logic loop_en, loop_rst, busy, done, res_valid;

  // Enable stays up across the LOADs between points
  always_comb begin
    loop_en   = 1'b0;
    loop_rst  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      S_PRE:  loop_rst = 1'b1;
      S_LOAD: loop_en  = (idx_q != '0);
      S_RUN:  loop_en  = 1'b1;
      S_REC: begin
        loop_en   = 1'b1;
        res_valid = 1'b1;
      end
      S_GAP: begin
        loop_en  = 1'b1;
        loop_rst = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  assign bus.q_desired   = q_q;
  assign bus.loop_en     = loop_en;
  assign bus.loop_rst    = loop_rst;
  assign bus.busy        = busy;
  assign bus.done        = done;
  assign bus.res_valid   = res_valid;
  assign bus.res_idx     = ridx_q;
  assign bus.res_timeout = rtmo_q;
  assign bus.res_cycles  = rcyc_q;
  assign bus.pass_cnt    = pass_q;
  assign bus.tmo_cnt     = tmo_q;
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
  assign bus.sweep_err   = err_q && (state_q == S_DONE);
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_q_sweep_sequencer.sv
// Directed bench for q_sweep_sequencer.
// Timeout shortened to 16 cycles.
module tb_q_sweep_sequencer;
  localparam int TMO = 16;
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  q_sweep_if #(.TIMEOUT_CYCLES(TMO)) bus ();
  q_sweep_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] lfsr_m;

  typedef struct {
    string nm;
    logic  m;
    int    conv_at;
    int    pts;
    logic  tmo;
    int    cyc;
    int    pass;
    int    tmo_n;
    logic  err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int lo_of(input int i);
    int t[4] = '{40, 60, 80, 100};
    return t[i];
  endfunction

  function automatic int hi_of(input int i);
    int t[4] = '{60, 100, 140, 180};
    return t[i];
  endfunction

  function automatic int exp_q(input logic m, input int i,
                               input logic [15:0] l);
    longint off;
    if (!m) return lo_of(i);
    off = (longint'(l) * longint'(20 * (i + 1) + 1)) >> 16;
    return lo_of(i) + int'(off);
  endfunction

  task automatic run_sweep(input vec_t v);
    int  k = -100;
    int  npts = 0;
    int  prelen = 0;
    bit  first = 1'b1;
    bit  fin = 1'b0;
    int  eq, lastq;
    @(negedge clk);
    bus.mode  = v.m;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mode  = ~v.m;
    chk({v.nm, ".pre_en"}, 32'(bus.loop_en), 0);
    chk({v.nm, ".busy"}, 32'(bus.busy), 1);
    chk({v.nm, ".clr_pass"}, 32'(bus.pass_cnt), 0);
    for (int c = 0; c < 2000 && !fin; c++) begin
      if (c > 0) @(negedge clk);
      if (bus.loop_rst) begin
        k = -1;
        if (first) prelen++;
      end else begin
        if (first && prelen > 0) begin
          chk({v.nm, ".pre_len"}, 32'(prelen), 5);
          first = 1'b0;
        end
        k++;
      end
      if (bus.res_valid && npts < 4) begin
        eq = exp_q(v.m, npts, lfsr_m);
        chk({v.nm, ".idx"}, 32'(bus.res_idx), 32'(npts));
        chk({v.nm, ".tmo"}, 32'(bus.res_timeout), 32'(v.tmo));
        chk({v.nm, ".cyc"}, 32'(bus.res_cycles), 32'(v.cyc));
        chk({v.nm, ".q"}, 32'(bus.q_desired), 32'(eq));
        chk({v.nm, ".en"}, 32'(bus.loop_en), 1);
        if (v.m)
          chk({v.nm, ".win"},
              32'(bus.q_desired >= 10'(lo_of(npts)) &&
                  bus.q_desired <= 10'(hi_of(npts))), 1);
        lfsr_m = lstep(lfsr_m);
        npts++;
      end
      if (bus.done) fin = 1'b1;
      bus.converged = (v.conv_at > 0 && k == v.conv_at);
    end
    bus.converged = 1'b0;
    chk({v.nm, ".done"}, 32'(fin), 1);
    chk({v.nm, ".npts"}, 32'(npts), 32'(v.pts));
    chk({v.nm, ".pass"}, 32'(bus.pass_cnt), 32'(v.pass));
    chk({v.nm, ".tmo_cnt"}, 32'(bus.tmo_cnt), 32'(v.tmo_n));
    chk({v.nm, ".busy_end"}, 32'(bus.busy), 0);
    chk({v.nm, ".en_end"}, 32'(bus.loop_en), 0);
`ifdef SWEEP_STOP_ON_TIMEOUT_EN
    chk({v.nm, ".err"}, 32'(bus.sweep_err), 32'(v.err));
`endif
    lastq = int'(bus.q_desired);
    repeat (3) @(negedge clk);
    chk({v.nm, ".hold_q"}, 32'(bus.q_desired), 32'(lastq));
    chk({v.nm, ".hold_done"}, 32'(bus.done), 1);
  endtask

  vec_t vecs[7];
  int k, nrec, seen;
  bit hit;

  initial begin
    vecs[0] = '{"conv10", 1'b0, 10, 4, 1'b0, 10, 4, 0, 1'b0};
    vecs[1] = '{"timeout", 1'b0, 0, STOP ? 1 : 4, 1'b1, TMO,
                0, STOP ? 1 : 4, STOP};
    vecs[2] = '{"conv_at_tmo", 1'b0, TMO, 4, 1'b0, TMO, 4, 0, 1'b0};
    vecs[3] = '{"conv1", 1'b0, 1, 4, 1'b0, 1, 4, 0, 1'b0};
    vecs[4] = '{"rand_a", 1'b1, 3, 4, 1'b0, 3, 4, 0, 1'b0};
    vecs[5] = '{"rand_b", 1'b1, 7, 4, 1'b0, 7, 4, 0, 1'b0};
    vecs[6] = '{"rand_c", 1'b1, 2, 4, 1'b0, 2, 4, 0, 1'b0};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode = 1'b0;
    bus.converged = 1'b0;
    rst_n = 1'b0;
    lfsr_m = 16'hACE1;
    #12;
    chk("rst.q", 32'(bus.q_desired), 0);
    chk("rst.busy", 32'(bus.busy), 0);
    chk("rst.done", 32'(bus.done), 0);
    chk("rst.lrst", 32'(bus.loop_rst), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_sweep(vecs[i]);

    // abort during RUN of point 2
    @(negedge clk);
    bus.mode = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = -100;
    nrec = 0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      if (c > 0) @(negedge clk);
      k = bus.loop_rst ? -1 : k + 1;
      if (bus.res_valid) begin
        nrec++;
        lfsr_m = lstep(lfsr_m);
      end
      if (nrec == 2 && k == 3) hit = 1'b1;
      bus.converged = (k == 5);
    end
    chk("abort.reached", 32'(hit), 1);
    bus.converged = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    lfsr_m = lstep(lfsr_m);
    chk("abort.busy", 32'(bus.busy), 0);
    chk("abort.en", 32'(bus.loop_en), 0);
    chk("abort.lrst", 32'(bus.loop_rst), 0);
    chk("abort.done", 32'(bus.done), 0);
    chk("abort.pass", 32'(bus.pass_cnt), 2);
    chk("abort.q", 32'(bus.q_desired), 80);
    seen = int'(bus.res_valid);
    repeat (5) begin
      @(negedge clk);
      seen += int'(bus.res_valid);
    end
    chk("abort.no_res", 32'(seen), 0);
    run_sweep('{"after_abort", 1'b1, 4, 4, 1'b0, 4, 4, 0, 1'b0});

    // async reset during GAP_RST
    @(negedge clk);
    bus.mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 500 && !hit; c++) begin
      @(negedge clk);
      if (bus.res_valid) hit = 1'b1;
      bus.converged = !bus.loop_rst && !bus.res_valid;
    end
    bus.converged = 1'b0;
    chk("rstmid.rec", 32'(hit), 1);
    @(negedge clk);
    @(negedge clk);
    chk("rstmid.in_gap", 32'(bus.loop_rst), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.q", 32'(bus.q_desired), 0);
    chk("rstmid.en", 32'(bus.loop_en), 0);
    chk("rstmid.lrst", 32'(bus.loop_rst), 0);
    chk("rstmid.busy", 32'(bus.busy), 0);
    chk("rstmid.pass", 32'(bus.pass_cnt), 0);
    chk("rstmid.rcyc", 32'(bus.res_cycles), 0);
    @(negedge clk);
    rst_n = 1'b1;
    lfsr_m = 16'hACE1;
    run_sweep('{"after_rst", 1'b1, 2, 4, 1'b0, 2, 4, 0, 1'b0});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
